// File: rtl/pin_scan_pkg.sv
// Shared types and constants for the pin identification blink sequencer.
package pin_scan_pkg;

    // Sequencer phases of one blink frame.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LETTER = 3'd1,
        GAP1   = 3'd2,
        NUMBER = 3'd3,
        GAP2   = 3'd4
    } state_t;

    // Output mode selection.
    localparam logic [1:0] MODE_PATTERN = 2'b00;
    localparam logic [1:0] MODE_OFF     = 2'b01;
    localparam logic [1:0] MODE_ON      = 2'b10;
    localparam logic [1:0] MODE_WALK    = 2'b11;

    // Letter codes for the header row, A=1 .. Z=26.
    localparam logic [4:0] LTR_A = 5'd1,  LTR_B = 5'd2,  LTR_C = 5'd3,  LTR_D = 5'd4;
    localparam logic [4:0] LTR_E = 5'd5,  LTR_F = 5'd6,  LTR_G = 5'd7,  LTR_H = 5'd8;
    localparam logic [4:0] LTR_I = 5'd9,  LTR_J = 5'd10, LTR_K = 5'd11, LTR_L = 5'd12;
    localparam logic [4:0] LTR_M = 5'd13, LTR_N = 5'd14, LTR_O = 5'd15, LTR_P = 5'd16;
    localparam logic [4:0] LTR_Q = 5'd17, LTR_R = 5'd18, LTR_S = 5'd19, LTR_T = 5'd20;
    localparam logic [4:0] LTR_U = 5'd21, LTR_V = 5'd22, LTR_W = 5'd23, LTR_X = 5'd24;
    localparam logic [4:0] LTR_Y = 5'd25, LTR_Z = 5'd26;

    // Elaboration-time maximum, used to size the slot counter.
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pin_scan_tick.sv
// Slot prescaler: one-cycle tick every TICK_DIV clocks while enabled.
module pin_scan_tick
    import pin_scan_pkg::*;
#(
    parameter int TICK_DIV = 6250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNTW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            wrap;

    assign wrap   = (cnt_q == CNTW'(TICK_DIV - 1));
    assign tick_o = en_i && wrap;

    // Next count: held at zero while disabled so a re-enable restarts a full slot.
    always_comb begin
        cnt_d = cnt_q + CNTW'(1);
        if (!en_i || wrap) begin
            cnt_d = '0;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pin_scan_seq.sv
// Multi-channel blink-code generator: shared prescaler and frame sequencer,
// per-channel pulse comparators, mode overrides and a registered output stage.
module pin_scan_seq
    import pin_scan_pkg::*;
#(
    parameter int              NUM_CH          = 16,
    parameter int              LW              = 5,
    parameter int              NW              = 4,
    parameter int              TICK_DIV        = 6250000,
    parameter int              GAP_SLOTS       = 3,
    parameter int              FRAME_GAP_SLOTS = 6,
    parameter logic [NUM_CH-1:0] INV_MASK      = {NUM_CH{1'b0}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [1:0]                 mode_i,
    input  logic [NUM_CH*LW-1:0]       code_l_i,
    input  logic [NUM_CH*NW-1:0]       code_n_i,
    output logic [NUM_CH-1:0]          pin_o,
    output logic                       frame_o,
    output logic [$clog2(NUM_CH)-1:0]  walk_idx_o
);

    // Slot counter must hold the longest phase: a pulse phase is 2*code slots.
    localparam int SLOT_MAX = imax(imax(2 * ((1 << LW) - 1), 2 * ((1 << NW) - 1)),
                                   imax(GAP_SLOTS, FRAME_GAP_SLOTS));
    localparam int SW = $clog2(SLOT_MAX + 1);
    localparam int CW = imax(SW, imax(LW, NW));
    localparam int WW = $clog2(NUM_CH);

    logic                   tick;
    state_t                 state_q;
    logic [SW-1:0]          slot_q;
    logic [WW-1:0]          walk_idx_q;
    logic [NUM_CH*LW-1:0]   code_l_q;
    logic [NUM_CH*NW-1:0]   code_n_q;
    logic [LW-1:0]          lmax_q;
    logic [NW-1:0]          nmax_q;
    logic [LW-1:0]          lmax_d;
    logic [NW-1:0]          nmax_d;
    logic                   frame_q;
    logic [NUM_CH-1:0]      pin_q;
    logic [NUM_CH-1:0]      raw;
    logic [SW-1:0]          letter_last;
    logic [SW-1:0]          number_last;
    logic                   frame_start;

    pin_scan_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .tick_o (tick)
    );

    // Largest incoming codes set the pulse-phase lengths of the next frame.
    always_comb begin
        lmax_d = '0;
        nmax_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (code_l_i[c*LW +: LW] > lmax_d) lmax_d = code_l_i[c*LW +: LW];
            if (code_n_i[c*NW +: NW] > nmax_d) nmax_d = code_n_i[c*NW +: NW];
        end
    end

    assign letter_last = SW'({lmax_q, 1'b0}) - SW'(1);
    assign number_last = SW'({nmax_q, 1'b0}) - SW'(1);
    assign frame_start = tick && ((state_q == IDLE) ||
                         ((state_q == GAP2) && (slot_q == SW'(FRAME_GAP_SLOTS - 1))));

    // Frame sequencer: advances one slot per tick, latches codes at frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            walk_idx_q <= '0;
            code_l_q   <= '0;
            code_n_q   <= '0;
            lmax_q     <= '0;
            nmax_q     <= '0;
            frame_q    <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            if (!en_i) begin
                state_q <= IDLE;
                slot_q  <= '0;
            end else if (frame_start) begin
                code_l_q <= code_l_i;
                code_n_q <= code_n_i;
                lmax_q   <= lmax_d;
                nmax_q   <= nmax_d;
                frame_q  <= 1'b1;
                slot_q   <= '0;
                state_q  <= (lmax_d == '0) ? GAP1 : LETTER;
                // Walk steps only between consecutive frames, not on a cold start.
                if (state_q == GAP2) begin
                    walk_idx_q <= (walk_idx_q == WW'(NUM_CH - 1)) ? '0 : walk_idx_q + WW'(1);
                end
            end else if (tick) begin
                case (state_q)
                    LETTER: begin
                        if (slot_q == letter_last) begin
                            state_q <= GAP1;
                            slot_q  <= '0;
                        end else begin
                            slot_q <= slot_q + SW'(1);
                        end
                    end
                    GAP1: begin
                        if (slot_q == SW'(GAP_SLOTS - 1)) begin
                            state_q <= (nmax_q == '0) ? GAP2 : NUMBER;
                            slot_q  <= '0;
                        end else begin
                            slot_q <= slot_q + SW'(1);
                        end
                    end
                    NUMBER: begin
                        if (slot_q == number_last) begin
                            state_q <= GAP2;
                            slot_q  <= '0;
                        end else begin
                            slot_q <= slot_q + SW'(1);
                        end
                    end
                    GAP2: begin
                        slot_q <= slot_q + SW'(1);
                    end
                    default: begin
                        state_q <= IDLE;
                        slot_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Per-channel comparators: pulse on even slots while slot/2 is below the code.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [LW-1:0] cl;
        logic [NW-1:0] cn;
        logic          pulse;
        logic          walk_ok;

        assign cl = code_l_q[c*LW +: LW];
        assign cn = code_n_q[c*NW +: NW];

        assign pulse = !slot_q[0] &&
                       (((state_q == LETTER) && (CW'(slot_q[SW-1:1]) < CW'(cl))) ||
                        ((state_q == NUMBER) && (CW'(slot_q[SW-1:1]) < CW'(cn))));

        assign walk_ok = (mode_i != MODE_WALK) || (walk_idx_q == WW'(c));

        assign raw[c] = en_i && ((mode_i == MODE_ON) ||
                                 ((mode_i != MODE_OFF) && walk_ok && pulse));
    end

    // Output stage: polarity applied and registered one cycle behind the sequencer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pin_q <= INV_MASK;
        end else begin
            pin_q <= raw ^ INV_MASK;
        end
    end

    assign pin_o      = pin_q;
    assign frame_o    = frame_q;
    assign walk_idx_o = walk_idx_q;

endmodule

// File: tb/tb_pin_scan_seq.sv
// Directed bench for pin_scan_seq: 2 channels, 2-clock slots, ch1 active-low.
module tb_pin_scan_seq;

    localparam int NUM_CH = 2;
    localparam int LW     = 5;
    localparam int NW     = 4;

    logic                     clk = 1'b0;
    logic                     rst_i;
    logic                     en_i;
    logic [1:0]               mode_i;
    logic [NUM_CH*LW-1:0]     code_l_i;
    logic [NUM_CH*NW-1:0]     code_n_i;
    logic [NUM_CH-1:0]        pin_o;
    logic                     frame_o;
    logic [0:0]               walk_idx_o;

    int n_checks = 0;
    int n_errors = 0;

    // Raw-high slot masks (bit f = frame slot f) derived by hand from the codes.
    localparam logic [31:0] PAT_CH0  = 32'h0000_0A15; // LETTER 0,2,4 ; NUMBER 0,2 (f 9,11)
    localparam logic [31:0] PAT_CH1  = 32'h0000_0001; // LETTER 0 only
    localparam logic [31:0] ONE_CH0  = 32'h0000_00A1; // L=1: f0 ; NUMBER at f5,f7
    localparam logic [31:0] ONE_CH1  = 32'h0000_0001;

    pin_scan_seq #(
        .NUM_CH          (NUM_CH),
        .LW              (LW),
        .NW              (NW),
        .TICK_DIV        (2),
        .GAP_SLOTS       (3),
        .FRAME_GAP_SLOTS (6),
        .INV_MASK        (2'b10)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .code_l_i   (code_l_i),
        .code_n_i   (code_n_i),
        .pin_o      (pin_o),
        .frame_o    (frame_o),
        .walk_idx_o (walk_idx_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count negedges until frame_o is seen (bounded), then check the distance.
    task automatic wait_frame(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_o && n < 200);
        check(tag, n, exp_cycles);
    endtask

    // Starting at a frame_o sample, check every pin sample through the next frame_o.
    task automatic run_frame(input string tag, input logic [31:0] ch0_hi,
                             input logic [31:0] ch1_hi, input int nslots,
                             input logic [0:0] walk_exp);
        int f;
        logic [1:0] e;
        check({tag, " walk"}, walk_idx_o, walk_exp);
        for (int i = 0; i < 2 * nslots; i++) begin
            @(negedge clk);
            f = i / 2;
            e = {~ch1_hi[f], ch0_hi[f]};
            check($sformatf("%s pin f=%0d", tag, f), pin_o, e);
            check($sformatf("%s frame i=%0d", tag, i), frame_o, (i == 2 * nslots - 1));
        end
    endtask

    task automatic set_pattern_codes();
        code_l_i = {5'd1, 5'd3};
        code_n_i = {4'd0, 4'd2};
    endtask

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b1;
        mode_i = 2'b00;
        set_pattern_codes();

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset pin", pin_o, 2'b10);
        check("reset frame", frame_o, 1'b0);
        check("reset walk", walk_idx_o, 1'b0);
        rst_i = 1'b0;

        // Pattern: first frame two clocks after release, 19-slot frames.
        wait_frame("first frame latency", 2);
        run_frame("A pattern", PAT_CH0, PAT_CH1, 19, 1'b0);

        // Mid-frame code change: current frame keeps 3 pulses.
        code_l_i = {5'd1, 5'd1};
        run_frame("B midchange", PAT_CH0, PAT_CH1, 19, 1'b1);
        code_l_i = '0;
        code_n_i = '0;
        run_frame("C newcode", ONE_CH0, ONE_CH1, 15, 1'b0);

        // Zero codes: 9-slot frames, outputs idle.
        set_pattern_codes();
        mode_i = 2'b11;
        run_frame("D zero", 32'h0, 32'h0, 9, 1'b1);

        // Walk mode.
        run_frame("E walk0", PAT_CH0, 32'h0, 19, 1'b0);
        run_frame("F walk1", 32'h0, PAT_CH1, 19, 1'b1);

        // Force modes mid-frame, then resume without disturbing the frame timing.
        check("G walk wrap", walk_idx_o, 1'b0);
        mode_i = 2'b10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("force on k=%0d", k), pin_o, 2'b01);
        end
        mode_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("force off k=%0d", k), pin_o, 2'b10);
        end
        mode_i = 2'b00;
        @(negedge clk);
        check("resume pin", pin_o, 2'b11);
        wait_frame("resume frame period", 29);

        // Reset in the middle of NUMBER.
        check("H walk", walk_idx_o, 1'b1);
        repeat (19) @(negedge clk);
        check("in NUMBER pin", pin_o, 2'b11);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort pin", pin_o, 2'b10);
        check("abort walk", walk_idx_o, 1'b0);
        check("abort frame", frame_o, 1'b0);
        rst_i = 1'b0;
        wait_frame("restart latency", 2);
        run_frame("I restart", PAT_CH0, PAT_CH1, 19, 1'b0);

        // Enable drop and re-enable from IDLE.
        repeat (5) @(negedge clk);
        en_i   = 1'b0;
        mode_i = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("disabled pin k=%0d", k), pin_o, 2'b10);
            check($sformatf("disabled frame k=%0d", k), frame_o, 1'b0);
            check($sformatf("disabled walk k=%0d", k), walk_idx_o, 1'b1);
        end
        en_i = 1'b1;
        @(negedge clk);
        check("reenable force on", pin_o, 2'b01);
        check("reenable no frame", frame_o, 1'b0);
        wait_frame("reenable frame latency", 1);
        check("reenable walk held", walk_idx_o, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
